mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Parametrised N-master arbiter in front of the single-port memory_bus.
//  Lets several requesters (e.g. IF fetch port, MEM data port, debug/DMA) share one memory.
//  Arbitration is round-robin and stall-aware; reads of fixed latency are routed back to their issuer.
//  Sits between riscv_pipelined_core (split I/D ports) and memory_bus in the pipelined top.
// PARAMETERS
//  WIDTH         32  data/address width in bits
//  NUM_MASTERS   2   number of requesters, 1..8
//  READ_LATENCY  1   cycles from read issue to valid i_mem_read_data, 1..4
// PORTS
//  i_clk             in   1                clock, all state on rising edge
//  i_reset_n         in   1                asynchronous, active-low reset
//  i_req             in   NUM_MASTERS      per-master request; held with payload until granted
//  i_we              in   NUM_MASTERS      per-master: 1 = write, 0 = read
//  i_addr            in   NUM_MASTERS*WIDTH  packed addresses, master k at [k*WIDTH +: WIDTH]
//  i_wdata           in   NUM_MASTERS*WIDTH  packed write data
//  i_byteen          in   NUM_MASTERS*4    packed byte enables
//  o_gnt             out  NUM_MASTERS      one-hot: request of master k accepted this cycle
//  o_rvalid          out  NUM_MASTERS      one-hot: read data for master k on o_rdata this cycle
//  o_rdata           out  WIDTH            read data (shared by all masters)
//  i_mem_ready       in   1                downstream can accept a transaction this cycle
//  o_mem_addr        out  WIDTH            to memory_bus addr_in
//  o_mem_write_data  out  WIDTH            to memory_bus data_in
//  o_mem_byteen      out  4                to memory_bus byteen
//  o_mem_write_en    out  1                to memory_bus mem_write
//  o_mem_read_en     out  1                to memory_bus mem_read
//  i_mem_read_data   in   WIDTH            from memory_bus mem_data_out
// BEHAVIOUR
//  Reset (i_reset_n=0, async): rr_ptr=0; read-tag pipeline cleared.
//   While in reset: o_gnt, o_rvalid, o_mem_write_en and o_mem_read_en are 0; o_mem_addr, o_mem_write_data, o_mem_byteen and o_rdata are 0.
//  Arbitration is combinational, same cycle:
//   - Candidates are masters with i_req=1, searched in order rr_ptr, rr_ptr+1, ... mod NUM_MASTERS; first hit k wins.
//   - Grant only when i_mem_ready=1; otherwise o_gnt=0 and no downstream enable is driven.
//   - On grant: o_gnt[k]=1; o_mem_* carry master k's payload.
//   - o_mem_write_en = i_we[k]; o_mem_read_en = ~i_we[k].
//   - No grant: o_mem_write_en = o_mem_read_en = 0; addr/data/byteen are 0.
//  Pointer: on a rising edge with a grant to k, rr_ptr <= (k+1) mod NUM_MASTERS; otherwise unchanged.
//   - Wrap: k=NUM_MASTERS-1 gives rr_ptr=0. Starvation bound: a held request is granted within NUM_MASTERS grants.
//  Handshake: a transfer completes on the cycle i_req[k] & o_gnt[k].
//   - The master may change its payload or drop i_req only after that cycle.
//   - Dropping i_req before grant is allowed (request withdrawn, no side effect).
//  Read return: each granted read pushes {valid=1, id=k} into a READ_LATENCY-deep shift register; writes and idle cycles push valid=0.
//   - Exactly READ_LATENCY cycles after the grant cycle: o_rvalid[id]=1, o_rdata=i_mem_read_data. Otherwise o_rvalid=0 and o_rdata=0.
//   - The pipeline is fixed-latency and not blocked by i_mem_ready=0; back-to-back reads return back-to-back, in grant order.
//  Writes: no response; complete at grant.
//  Simultaneous events: a grant and a read return in the same cycle are independent.
//   - Master k may be granted while its earlier read is still in flight.
//  Reset mid-operation: in-flight reads are discarded and no o_rvalid follows; rr_ptr returns to 0.
//  NUM_MASTERS=1: the arbiter degenerates to a pass-through with o_gnt = i_req & i_mem_ready.
// TESTING
//  1 Reset: drive i_reset_n=0 with i_req=all-ones mid-cycle -> all outputs 0 immediately; after release the first grant goes to master 0.
//  2 Round-robin, N=3: i_req=3'b111 held 6 cycles, ready=1 -> o_gnt sequence 001,010,100,001,010,100.
//  3 Read routing, LAT=2: master1 reads 0x100 (mem returns 0xDEADBEEF) -> o_rvalid=2'b10 and o_rdata=0xDEADBEEF exactly 2 cycles after grant; no rvalid for writes.
//  4 Stall: i_mem_ready=0 for 3 cycles with i_req=2'b01 -> o_gnt=0 and no mem enables; grant in the first ready cycle with the payload unchanged.
//  5 Interleave, LAT=1: M0 read A, M1 write B, M0 read C on consecutive grants -> rvalid[0] on cycles 1 and 3 with data A, C; memory sees the write to B with byteen intact.
//  6 Reset with 2 reads in flight (LAT=3) -> no o_rvalid after reset release; rr_ptr=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin N-master arbiter in front of a single-port memory bus.
// Fixed-latency read data is routed back to the master that issued the read.
module mem_bus_arbiter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_MASTERS  = 2,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [NUM_MASTERS-1:0]       i_req,
  input  logic [NUM_MASTERS-1:0]       i_we,
  input  logic [NUM_MASTERS*WIDTH-1:0] i_addr,
  input  logic [NUM_MASTERS*WIDTH-1:0] i_wdata,
  input  logic [NUM_MASTERS*4-1:0]     i_byteen,
  output logic [NUM_MASTERS-1:0]       o_gnt,
  output logic [NUM_MASTERS-1:0]       o_rvalid,
  output logic [WIDTH-1:0]             o_rdata,
  input  logic                         i_mem_ready,
  output logic [WIDTH-1:0]             o_mem_addr,
  output logic [WIDTH-1:0]             o_mem_write_data,
  output logic [3:0]                   o_mem_byteen,
  output logic                         o_mem_write_en,
  output logic                         o_mem_read_en,
  input  logic [WIDTH-1:0]             i_mem_read_data
);

  localparam int unsigned PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] gnt_id;
  logic             gnt_any;
  logic             we_sel;

  logic [READ_LATENCY-1:0] tag_valid;
  logic [PTR_W-1:0]        tag_id [READ_LATENCY];

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return PTR_W'(sum % NUM_MASTERS);
  endfunction

  // Search from rr_ptr upwards; gating by reset keeps outputs quiet while held in reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = wrap_add(rr_ptr, i);
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
        if (!gnt_any && i_req[k] && (cand == PTR_W'(k))) begin
          gnt_any = 1'b1;
          gnt_id  = PTR_W'(k);
        end
      end
    end
    if (!i_mem_ready || !i_reset_n) begin
      gnt_any = 1'b0;
      gnt_id  = '0;
    end
  end

  always_comb begin
    o_gnt            = '0;
    o_mem_addr       = '0;
    o_mem_write_data = '0;
    o_mem_byteen     = '0;
    we_sel           = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (gnt_any && (gnt_id == PTR_W'(k))) begin
        o_gnt[k]         = 1'b1;
        o_mem_addr       = i_addr[k*WIDTH +: WIDTH];
        o_mem_write_data = i_wdata[k*WIDTH +: WIDTH];
        o_mem_byteen     = i_byteen[k*4 +: 4];
        we_sel           = i_we[k];
      end
    end
    o_mem_write_en = gnt_any & we_sel;
    o_mem_read_en  = gnt_any & ~we_sel;

    o_rvalid = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (tag_valid[READ_LATENCY-1] && (tag_id[READ_LATENCY-1] == PTR_W'(k))) begin
        o_rvalid[k] = 1'b1;
      end
    end
    o_rdata = tag_valid[READ_LATENCY-1] ? i_mem_read_data : '0;
  end

  // Tag pipeline shifts every cycle regardless of i_mem_ready so latency stays fixed.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_ptr    <= '0;
      tag_valid <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      if (gnt_any) begin
        rr_ptr <= wrap_add(gnt_id, 1);
      end
      for (int unsigned i = READ_LATENCY - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      tag_valid[0] <= gnt_any & ~we_sel;
      tag_id[0]    <= gnt_id;
    end
  end

endmodule
